// File: rtl/obi_pkg.sv
// Shared OBI types for the instruction/data port arbiter in front of the SRAM.
// Master IDs double as owner-FIFO entries, so responses can be routed back.
package obi_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;

  typedef logic obi_id_t;

  localparam obi_id_t OBI_M_INSTR = 1'b0;
  localparam obi_id_t OBI_M_DATA  = 1'b1;

  typedef struct packed {
    logic                    req;
    logic [OBI_ADDR_W-1:0]   addr;
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_DATA_W-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_rsp_t;

  // Round-robin partner of a master: with two masters it is simply the other one.
  function automatic obi_id_t obi_other(input obi_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/obi_owner_fifo.sv
// Owner FIFO: records which master issued each accepted transaction so the
// in-order responses from the slave can be steered back to it.
module obi_owner_fifo
  import obi_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  obi_id_t          push_id,
  input  logic             pop,
  output obi_id_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  obi_id_t          mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-master to one-slave OBI arbiter: round-robin with a stall lock, zero
// added latency, responses steered back through an owner FIFO.
module obi_mem_arbiter
  import obi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  obi_id_t          last_q;
  logic             lock_q;
  obi_id_t          lock_id_q;
  obi_id_t          sel_id;
  logic             sel_req;
  logic             handshake;
  logic             stall;
  logic             rsp_pop;
  obi_id_t          fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // A stalled request keeps ownership so the address phase stays stable.
  always_comb begin
    sel_id  = OBI_M_INSTR;
    sel_req = 1'b0;
    if (lock_q) begin
      sel_id  = lock_id_q;
      sel_req = (lock_id_q == OBI_M_DATA) ? m1_req_i : m0_req_i;
    end else if (m0_req_i && m1_req_i) begin
      sel_id  = obi_other(last_q);
      sel_req = 1'b1;
    end else if (m1_req_i) begin
      sel_id  = OBI_M_DATA;
      sel_req = 1'b1;
    end else if (m0_req_i) begin
      sel_id  = OBI_M_INSTR;
      sel_req = 1'b1;
    end
  end

  assign s_req_o   = rst_ni && sel_req && (fifo_count < CNT_W'(MAX_OUTSTANDING));
  assign handshake = s_req_o && s_gnt_i;
  assign stall     = s_req_o && !s_gnt_i;
  assign m0_gnt_o  = handshake && (sel_id == OBI_M_INSTR);
  assign m1_gnt_o  = handshake && (sel_id == OBI_M_DATA);

  assign s_addr_o  = (sel_id == OBI_M_DATA) ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = (sel_id == OBI_M_DATA) ? m1_we_i    : m0_we_i;
  assign s_be_o    = (sel_id == OBI_M_DATA) ? m1_be_i    : m0_be_i;
  assign s_wdata_o = (sel_id == OBI_M_DATA) ? m1_wdata_i : m0_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q    <= OBI_M_DATA;
      lock_q    <= 1'b0;
      lock_id_q <= OBI_M_INSTR;
    end else if (handshake) begin
      last_q <= sel_id;
      lock_q <= 1'b0;
    end else if (stall) begin
      lock_q    <= 1'b1;
      lock_id_q <= sel_id;
    end
  end

  // A response with nothing outstanding is dropped rather than misrouted.
  assign rsp_pop     = s_rvalid_i && !fifo_empty;
  assign m0_rvalid_o = rst_ni && rsp_pop && (fifo_head == OBI_M_INSTR);
  assign m1_rvalid_o = rst_ni && rsp_pop && (fifo_head == OBI_M_DATA);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  obi_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (handshake),
    .push_id (sel_id),
    .pop     (rsp_pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  stray_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(s_rvalid_i && fifo_empty))
    else $warning("obi_mem_arbiter: s_rvalid_i with no outstanding transaction dropped");

  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(handshake && fifo_full));

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter against an SRAM-like slave model with
// configurable response latency and an optional stalling grant.
module tb_obi_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;

  int          n_checks, n_fail;
  int          lat;
  logic        gnt_auto, stub_gnt, stray;
  bit [31:0]   mem [64];
  bit          dly_v [8];
  logic [31:0] dly_d [8];

  always #5 clk_i = ~clk_i;

  obi_mem_arbiter #(
    .MAX_OUTSTANDING (2),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m0_req_i    (m0_req_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_addr_i   (m0_addr_i),
    .m0_we_i     (m0_we_i),
    .m0_be_i     (m0_be_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_req_i    (m1_req_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_addr_i   (m1_addr_i),
    .m1_we_i     (m1_we_i),
    .m1_be_i     (m1_be_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .s_req_o     (s_req_o),
    .s_gnt_i     (s_gnt_i),
    .s_addr_o    (s_addr_o),
    .s_we_o      (s_we_o),
    .s_be_o      (s_be_o),
    .s_wdata_o   (s_wdata_o),
    .s_rvalid_i  (s_rvalid_i),
    .s_rdata_i   (s_rdata_i)
  );

  assign s_gnt_i    = gnt_auto ? s_req_o : stub_gnt;
  assign s_rvalid_i = dly_v[0] | stray;
  assign s_rdata_i  = dly_d[0];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Slave model: accepts on handshake, answers after lat cycles, in order.
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 8; i++) dly_v[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        dly_v[i] <= dly_v[i+1];
        dly_d[i] <= dly_d[i+1];
      end
      dly_v[7] <= 1'b0;
      if (s_req_o && s_gnt_i) begin
        dly_v[lat-1] <= 1'b1;
        dly_d[lat-1] <= s_we_o ? 32'h0 : mem[s_addr_o[7:2]];
        if (s_we_o) mem[s_addr_o[7:2]] <= merge(mem[s_addr_o[7:2]], s_wdata_o, s_be_o);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int id, input logic req, input logic [31:0] addr,
                       input logic we, input logic [31:0] wdata, input logic [3:0] be);
    if (id == 0) begin
      m0_req_i = req; m0_addr_i = addr; m0_we_i = we; m0_wdata_i = wdata; m0_be_i = be;
    end else begin
      m1_req_i = req; m1_addr_i = addr; m1_we_i = we; m1_wdata_i = wdata; m1_be_i = be;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_sreq [10] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    int          exp_rv   [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    logic [31:0] exp_rd   [10];
    logic [31:0] addr_t   [6] = '{32'h10, 32'h0, 32'h10, 32'h10, 32'h10, 32'h10};
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h00BB00DD,
               32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
    n_checks = 0; n_fail = 0;
    lat = 1; gnt_auto = 1'b1; stub_gnt = 1'b0; stray = 1'b0;
    rst_ni = 1'b0;

    // Reset: requests present but everything forced low
    drive(0, 1'b1, 32'h10, 1'b0, 32'h0, 4'hF);
    drive(1, 1'b1, 32'h20, 1'b0, 32'h0, 4'hF);
    #3;
    chk("rst_s_req", s_req_o, 0);
    chk("rst_m0_gnt", m0_gnt_o, 0);
    chk("rst_m1_gnt", m1_gnt_o, 0);
    drive(0, 1'b0, 32'h55, 1'b0, 32'h0, 4'hF);
    drive(1, 1'b0, 32'h66, 1'b0, 32'h0, 4'hF);
    step(); step();
    rst_ni = 1'b1;
    #1;
    chk("idle_s_req", s_req_o, 0);
    chk("idle_addr_m0", s_addr_o, 32'h55);
    step();

    // Contention: alternate starting with m0, one per cycle
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, 32'h40, 1'b0, 32'h0, 4'hF);
      drive(1, 1'b1, 32'h44, 1'b0, 32'h0, 4'hF);
      #1;
      chk($sformatf("cont_m0_gnt[%0d]", i), m0_gnt_o, (i % 2 == 0));
      chk($sformatf("cont_m1_gnt[%0d]", i), m1_gnt_o, (i % 2 == 1));
      chk($sformatf("cont_m0_rv[%0d]", i), m0_rvalid_o, (i > 0) && ((i - 1) % 2 == 0));
      chk($sformatf("cont_m1_rv[%0d]", i), m1_rvalid_o, (i > 0) && ((i - 1) % 2 == 1));
      step();
    end
    drive(0, 1'b0, 32'h40, 1'b0, 32'h0, 4'hF);
    drive(1, 1'b0, 32'h44, 1'b0, 32'h0, 4'hF);
    #1;
    chk("cont_last_m1_rv", m1_rvalid_o, 1);
    chk("cont_last_m0_rv", m0_rvalid_o, 0);
    step();

    // Single master: preload 0x10 then read it back
    drive(0, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    #1 chk("wr_m0_gnt", m0_gnt_o, 1);
    step();
    drive(0, 1'b1, 32'h10, 1'b0, 32'h0, 4'hF);
    #1;
    chk("wr_m0_rv", m0_rvalid_o, 1);
    chk("rd_m0_gnt", m0_gnt_o, 1);
    step();
    drive(0, 1'b0, 32'h10, 1'b0, 32'h0, 4'hF);
    #1;
    chk("rd_m0_rv", m0_rvalid_o, 1);
    chk("rd_m0_rdata", m0_rdata_o, 32'hDEADBEEF);
    chk("rd_m1_rv", m1_rvalid_o, 0);
    step();

    // Stall with lock: last owner is m0, so m1 would win without the lock
    gnt_auto = 1'b0; stub_gnt = 1'b0;
    drive(0, 1'b1, 32'h100, 1'b0, 32'h0, 4'hF);
    #1;
    chk("stall0_s_req", s_req_o, 1);
    chk("stall0_m0_gnt", m0_gnt_o, 0);
    chk("stall0_addr", s_addr_o, 32'h100);
    step();
    drive(1, 1'b1, 32'h200, 1'b0, 32'h0, 4'hF);
    #1;
    chk("stall1_addr", s_addr_o, 32'h100);
    chk("stall1_m1_gnt", m1_gnt_o, 0);
    step();
    #1 chk("stall2_addr", s_addr_o, 32'h100);
    step();
    stub_gnt = 1'b1;
    #1;
    chk("stall3_m0_gnt", m0_gnt_o, 1);
    chk("stall3_m1_gnt", m1_gnt_o, 0);
    chk("stall3_addr", s_addr_o, 32'h100);
    step();
    drive(0, 1'b0, 32'h100, 1'b0, 32'h0, 4'hF);
    #1;
    chk("stall4_m1_gnt", m1_gnt_o, 1);
    chk("stall4_addr", s_addr_o, 32'h200);
    chk("stall4_m0_rv", m0_rvalid_o, 1);
    step();
    drive(1, 1'b0, 32'h200, 1'b0, 32'h0, 4'hF);
    stub_gnt = 1'b0; gnt_auto = 1'b1;
    #1 chk("stall5_m1_rv", m1_rvalid_o, 1);
    step();

    // Byte-enable write then read from m1
    drive(1, 1'b1, 32'h0, 1'b1, 32'hAABBCCDD, 4'b0101);
    #1 chk("be_wr_m1_gnt", m1_gnt_o, 1);
    step();
    drive(1, 1'b1, 32'h0, 1'b0, 32'h0, 4'hF);
    #1;
    chk("be_wr_m1_rv", m1_rvalid_o, 1);
    chk("be_rd_m1_gnt", m1_gnt_o, 1);
    step();
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'hF);
    #1;
    chk("be_rd_m1_rv", m1_rvalid_o, 1);
    chk("be_rd_m1_rdata", m1_rdata_o, 32'h00BB00DD);
    chk("be_rd_m0_rv", m0_rvalid_o, 0);
    step();

    // Full FIFO: slave answers 4 cycles after grant
    lat = 4;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) drive(0, 1'b1, addr_t[c], 1'b0, 32'h0, 4'hF);
      else       drive(0, 1'b0, 32'h10, 1'b0, 32'h0, 4'hF);
      #1;
      chk($sformatf("full_s_req[%0d]", c), s_req_o, exp_sreq[c]);
      chk($sformatf("full_m0_rv[%0d]", c), m0_rvalid_o, exp_rv[c]);
      if (exp_rv[c] != 0) chk($sformatf("full_m0_rdata[%0d]", c), m0_rdata_o, exp_rd[c]);
      step();
    end
    lat = 1;

    // Reset while one transaction is outstanding
    drive(0, 1'b1, 32'h10, 1'b0, 32'h0, 4'hF);
    #1 chk("rmf_m0_gnt", m0_gnt_o, 1);
    step();
    drive(1, 1'b1, 32'h20, 1'b0, 32'h0, 4'hF);
    rst_ni = 1'b0;
    #1;
    chk("rmf_s_req", s_req_o, 0);
    chk("rmf_m0_gnt_low", m0_gnt_o, 0);
    chk("rmf_m1_gnt_low", m1_gnt_o, 0);
    chk("rmf_m0_rv_low", m0_rvalid_o, 0);
    chk("rmf_m1_rv_low", m1_rvalid_o, 0);
    step(); step();
    drive(0, 1'b0, 32'h10, 1'b0, 32'h0, 4'hF);
    drive(1, 1'b0, 32'h20, 1'b0, 32'h0, 4'hF);
    rst_ni = 1'b1;
    step();
    stray = 1'b1;
    #1;
    chk("stray_m0_rv", m0_rvalid_o, 0);
    chk("stray_m1_rv", m1_rvalid_o, 0);
    step();
    stray = 1'b0;
    drive(0, 1'b1, 32'h10, 1'b0, 32'h0, 4'hF);
    drive(1, 1'b1, 32'h0, 1'b0, 32'h0, 4'hF);
    #1;
    chk("post_rst_m0_gnt", m0_gnt_o, 1);
    chk("post_rst_m1_gnt", m1_gnt_o, 0);
    step();
    #1;
    chk("post_rst_m1_gnt2", m1_gnt_o, 1);
    chk("post_rst_m0_rv", m0_rvalid_o, 1);
    chk("post_rst_m0_rdata", m0_rdata_o, 32'hDEADBEEF);
    step();
    drive(0, 1'b0, 32'h10, 1'b0, 32'h0, 4'hF);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'hF);
    #1;
    chk("post_rst_m1_rv", m1_rvalid_o, 1);
    chk("post_rst_m1_rdata", m1_rdata_o, 32'h00BB00DD);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
